pv_client_ctrl: RTL and testbench



---
 rtl/pv_client_ctrl_if.sv | 40 ++++
 rtl/pv_client_ctrl.sv | 124 ++++++++++++
 tb/tb_pv_client_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pv_client_ctrl_if.sv
// PCR vault client types and the bundled read/write port interface (client = master, vault = slave).
package pv_client_pkg;
  localparam int PV_NUM_DWORDS   = 12;
  localparam int PV_ENTRY_ADDR_W = 5;
  localparam int PV_ENTRY_SIZE_W = 4;

  typedef struct packed {
    logic [PV_ENTRY_ADDR_W-1:0] read_entry;
    logic [PV_ENTRY_SIZE_W-1:0] read_offset;
  } pv_read_t;

  typedef struct packed {
    logic [31:0] read_data;
    logic        last;
    logic        error;
  } pv_rd_resp_t;

  typedef struct packed {
    logic                       write_en;
    logic [PV_ENTRY_ADDR_W-1:0] write_entry;
    logic [PV_ENTRY_SIZE_W-1:0] write_offset;
    logic [31:0]                write_data;
  } pv_write_t;

  typedef struct packed {
    logic error;
  } pv_wr_resp_t;
endpackage

interface pv_client_ctrl_if;
  import pv_client_pkg::*;

  pv_read_t    pv_read;
  pv_rd_resp_t pv_rd_resp;
  pv_write_t   pv_write;
  pv_wr_resp_t pv_wr_resp;

  modport master (output pv_read, pv_write, input pv_rd_resp, pv_wr_resp);
  modport slave  (input pv_read, pv_write, output pv_rd_resp, pv_wr_resp);
endinterface

// File: rtl/pv_client_ctrl.sv
// Requester for one PCR vault read slot and one write slot: full-entry read into a buffer, full-entry digest write.
// Optional macro PV_CLIENT_LAST_CHECK_EN: abort a read early when the vault's last flag disagrees with the counter.
module pv_client_ctrl
  import pv_client_pkg::*;
#(
  parameter int NUM_DWORDS = PV_NUM_DWORDS,
  parameter int ENTRY_W    = PV_ENTRY_ADDR_W,
  parameter int OFFSET_W   = PV_ENTRY_SIZE_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_start,
  input  logic [ENTRY_W-1:0]      read_entry_i,
  input  logic                    write_start,
  input  logic [ENTRY_W-1:0]      write_entry_i,
  input  logic [NUM_DWORDS*32-1:0] wr_data_i,
  pv_client_ctrl_if.master        pv,
  output logic [NUM_DWORDS*32-1:0] rd_data_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  localparam logic [OFFSET_W-1:0] LAST_OFF = OFFSET_W'(NUM_DWORDS-1);

  state_t                     state, state_nxt;
  logic [OFFSET_W-1:0]        cnt;
  logic [OFFSET_W-1:0]        dw_idx;
  logic [ENTRY_W-1:0]         entry;
  logic [NUM_DWORDS-1:0][31:0] rd_buf;
  logic [NUM_DWORDS-1:0][31:0] wr_snap;
  logic                       error_q;
  logic                       at_last;
  logic                       last_mismatch;
  pv_read_t                   rd_req;
  pv_write_t                  wr_req;

  assign at_last = (cnt == LAST_OFF);
  // Dword 0 lives in the most significant slot of the packed buffers.
  assign dw_idx  = LAST_OFF - cnt;

`ifdef PV_CLIENT_LAST_CHECK_EN
  assign last_mismatch = (pv.pv_rd_resp.last != at_last);
`else
  assign last_mismatch = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rd_req    = '0;
    wr_req    = '0;
    case (state)
      IDLE: begin
        if (read_start)       state_nxt = READ;
        else if (write_start) state_nxt = WRITE;
      end
      READ: begin
        rd_req.read_entry  = PV_ENTRY_ADDR_W'(entry);
        rd_req.read_offset = PV_ENTRY_SIZE_W'(cnt);
        if (at_last || last_mismatch) state_nxt = DONE;
      end
      WRITE: begin
        wr_req.write_en     = 1'b1;
        wr_req.write_entry  = PV_ENTRY_ADDR_W'(entry);
        wr_req.write_offset = PV_ENTRY_SIZE_W'(cnt);
        wr_req.write_data   = wr_snap[dw_idx];
        if (at_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      entry   <= '0;
      rd_buf  <= '0;
      wr_snap <= '0;
      error_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (read_start) begin
            entry   <= read_entry_i;
            cnt     <= '0;
            error_q <= 1'b0;
          end else if (write_start) begin
            entry   <= write_entry_i;
            wr_snap <= wr_data_i;
            cnt     <= '0;
            error_q <= 1'b0;
          end
        end
        READ: begin
          rd_buf[dw_idx] <= pv.pv_rd_resp.read_data;
          error_q        <= error_q | pv.pv_rd_resp.error | last_mismatch;
          if (!at_last) cnt <= cnt + 1'b1;
        end
        WRITE: begin
          // Errors are accumulated but never cut the write short.
          error_q <= error_q | pv.pv_wr_resp.error;
          if (!at_last) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pv.pv_read  = rd_req;
  assign pv.pv_write = wr_req;
  assign rd_data_o   = rd_buf;
  assign busy_o      = (state != IDLE);
  assign done_o      = (state == DONE);
  assign error_o     = error_q;

endmodule

// File: tb/tb_pv_client_ctrl.sv
// Bench for pv_client_ctrl: behavioural vault array plus directed and random read/write operations.
module tb_pv_client_ctrl;
  import pv_client_pkg::*;

  localparam int N = PV_NUM_DWORDS;
  localparam int W = N*32;

  logic         clk = 1'b0;
  logic         rst;
  logic         read_start, write_start;
  logic [4:0]   read_entry_i, write_entry_i;
  logic [W-1:0] wr_data_i, rd_data_o;
  logic         busy_o, done_o, error_o;

  pv_client_ctrl_if pvif();

  pv_client_ctrl dut (
    .clk(clk), .rst(rst),
    .read_start(read_start), .read_entry_i(read_entry_i),
    .write_start(write_start), .write_entry_i(write_entry_i),
    .wr_data_i(wr_data_i), .pv(pvif),
    .rd_data_o(rd_data_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  logic [31:0] vault [32][16];
  int inj_rd_err = -1;
  int inj_wr_err = -1;
  int inj_last   = -1;
  int wr_cycles  = 0;
  int n_assert   = 0;
  int n_fail     = 0;

  // Vault responds combinationally; error/last faults are injected by offset.
  always_comb begin
    pvif.pv_rd_resp.read_data = vault[pvif.pv_read.read_entry][pvif.pv_read.read_offset];
    pvif.pv_rd_resp.last  = ((int'(pvif.pv_read.read_offset) == N-1) !=
                             (int'(pvif.pv_read.read_offset) == inj_last));
    pvif.pv_rd_resp.error = (int'(pvif.pv_read.read_offset) == inj_rd_err);
    pvif.pv_wr_resp.error = pvif.pv_write.write_en &&
                            (int'(pvif.pv_write.write_offset) == inj_wr_err);
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; the vault commits any write the client presented in that cycle.
  task automatic tick();
    logic we; logic [4:0] e; logic [3:0] o; logic [31:0] d;
    we = pvif.pv_write.write_en;
    e  = pvif.pv_write.write_entry;
    o  = pvif.pv_write.write_offset;
    d  = pvif.pv_write.write_data;
    @(posedge clk); #1;
    if (we) begin
      vault[e][o] = d;
      wr_cycles++;
    end
  endtask

  function automatic logic [W-1:0] vault_row(input int e);
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[W-1-32*k -: 32] = vault[e][k];
    return r;
  endfunction

  function automatic logic [W-1:0] rand_data();
    logic [W-1:0] r;
    for (int k = 0; k < N; k++) r[32*k +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy_o, 1'b0);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_pv_write"}, pvif.pv_write, '0);
    check({tag, "_pv_read"}, pvif.pv_read, '0);
  endtask

  task automatic do_read(input logic [4:0] e, input bit also_write);
    logic [W-1:0] exp;
    bit exp_err;
    int wr0;
    exp     = vault_row(e);
    exp_err = (inj_rd_err >= 0) && (inj_rd_err < N);
    wr0     = wr_cycles;
    read_entry_i  = e;
    read_start    = 1'b1;
    write_start   = also_write;
    write_entry_i = 5'($urandom);
    wr_data_i     = rand_data();
    tick();
    read_start  = 1'b0;
    write_start = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (k == 0) check("rd_err_cleared", error_o, 1'b0);
      check("rd_busy", busy_o, 1'b1);
      check("rd_entry", pvif.pv_read.read_entry, e);
      check("rd_offset", pvif.pv_read.read_offset, k);
      if (also_write && k == 2) write_start = 1'b1;
      tick();
      write_start = 1'b0;
    end
    check("rd_done", done_o, 1'b1);
    check("rd_data", rd_data_o, exp);
    check("rd_error", error_o, exp_err);
    check("rd_no_write", wr_cycles - wr0, 0);
    tick();
    check_idle_outputs("rd_after");
  endtask

  task automatic do_write(input logic [4:0] e, input logic [W-1:0] data);
    logic [W-1:0] prev_rd;
    bit exp_err;
    int wr0;
    prev_rd = rd_data_o;
    exp_err = (inj_wr_err >= 0) && (inj_wr_err < N);
    wr0     = wr_cycles;
    write_entry_i = e;
    wr_data_i     = data;
    write_start   = 1'b1;
    tick();
    write_start = 1'b0;
    wr_data_i   = rand_data();
    for (int k = 0; k < N; k++) begin
      if (k == 0) check("wr_err_cleared", error_o, 1'b0);
      check("wr_en", pvif.pv_write.write_en, 1'b1);
      check("wr_entry", pvif.pv_write.write_entry, e);
      check("wr_offset", pvif.pv_write.write_offset, k);
      check("wr_data", pvif.pv_write.write_data, data[W-1-32*k -: 32]);
      tick();
    end
    check("wr_done", done_o, 1'b1);
    check("wr_en_cycles", wr_cycles - wr0, N);
    check("wr_error", error_o, exp_err);
    check("wr_vault", vault_row(e), data);
    check("wr_rd_hold", rd_data_o, prev_rd);
    tick();
    check_idle_outputs("wr_after");
  endtask

  initial begin
    logic [W-1:0] prev;
    for (int e = 0; e < 32; e++)
      for (int k = 0; k < 16; k++) vault[e][k] = $urandom;
    rst = 1'b1;
    read_start = 1'b0; write_start = 1'b0;
    read_entry_i = '0; write_entry_i = '0; wr_data_i = '0;
    #12;
    check_idle_outputs("reset");
    check("reset_rd_data", rd_data_o, '0);
    check("reset_error", error_o, 1'b0);
    @(negedge clk) rst = 1'b0;
    repeat (5) tick();
    check_idle_outputs("idle5");
    check("idle5_error", error_o, 1'b0);

    for (int k = 0; k < N; k++) vault[3][k] = 32'hA000_0000 + k;
    do_read(5'd3, 1'b0);

    begin
      logic [W-1:0] d;
      for (int k = 0; k < N; k++) d[W-1-32*k -: 32] = 32'h5500_0000 + k;
      do_write(5'd5, d);
    end

    do_read(5'd5, 1'b1);

    inj_wr_err = 2;
    do_write(5'd9, rand_data());
    inj_wr_err = -1;
    do_read(5'd3, 1'b0);

    for (int i = 0; i < 10; i++) begin
      inj_rd_err = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, N-1)) : -1;
      inj_wr_err = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N-1)) : -1;
      if ($urandom_range(0, 1) == 1) do_read(5'($urandom), 1'($urandom));
      else                           do_write(5'($urandom), rand_data());
      repeat ($urandom_range(0, 2)) tick();
    end
    inj_rd_err = -1;
    inj_wr_err = -1;

    read_entry_i = 5'd3; read_start = 1'b1;
    tick();
    read_start = 1'b0;
    repeat (4) tick();
    check("rst_mid_offset_pre", pvif.pv_read.read_offset, 4);
    rst = 1'b1; #1;
    check("rst_mid_busy", busy_o, 1'b0);
    check("rst_mid_offset", pvif.pv_read.read_offset, '0);
    check("rst_mid_buf", rd_data_o, '0);
    @(negedge clk) rst = 1'b0;
    tick();

    write_entry_i = 5'd12; wr_data_i = rand_data(); write_start = 1'b1;
    tick();
    write_start = 1'b0;
    repeat (3) tick();
    check("rst_wr_en_pre", pvif.pv_write.write_en, 1'b1);
    rst = 1'b1; #1;
    check("rst_wr_fields", pvif.pv_write, '0);
    @(negedge clk) rst = 1'b0;
    tick();

    do_read(5'd3, 1'b0);
    prev = rd_data_o;
    for (int k = 0; k < N; k++) vault[7][k] = 32'h7700_0000 + k;
    inj_last = 1;
`ifdef PV_CLIENT_LAST_CHECK_EN
    read_entry_i = 5'd7; read_start = 1'b1;
    tick();
    read_start = 1'b0;
    tick();
    tick();
    check("last_abort_done", done_o, 1'b1);
    check("last_abort_error", error_o, 1'b1);
    prev[W-1 -: 64] = {32'h7700_0000, 32'h7700_0001};
    check("last_abort_buf", rd_data_o, prev);
    tick();
    check_idle_outputs("last_abort_after");
`else
    do_read(5'd7, 1'b0);
`endif
    inj_last = -1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
